// File: rtl/sram_like_pkg.sv
// Shared encodings and helpers for sram-like memory models and stimulus generators.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef struct packed {
        logic [3:0] be;
        logic       misaligned;
    } be_t;

    // Byte enables for an access; misaligned or reserved sizes give no enables
    function automatic be_t be_from_size(input logic [1:0] size, input logic [1:0] lo);
        be_t r;
        r.be         = 4'b0000;
        r.misaligned = 1'b0;
        case (size)
            SIZE_BYTE: r.be = 4'b0001 << lo;
            SIZE_HALF: begin
                if (lo[0]) r.misaligned = 1'b1;
                else       r.be = lo[1] ? 4'b1100 : 4'b0011;
            end
            SIZE_WORD: begin
                if (lo != 2'b00) r.misaligned = 1'b1;
                else             r.be = 4'b1111;
            end
            default:   r.misaligned = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR, free-running pseudo-random source for stall/stimulus patterns.
// Latency: state advances one step per enabled clock; reset loads SEED.
// Backpressure: none; en simply freezes the sequence.
module lfsr32 import sram_like_pkg::*; #(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] state
);

    // Shift right, folding the polynomial back in when a one drops out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    state <= SEED;
        else if (en) state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_POLY : 32'h0);
    end

endmodule

// File: rtl/sram_like_mem.sv
// Sram-like memory model: one request port, fixed response latency, bounded in-flight count.
// Latency: data_ok exactly LATENCY cycles after the acceptance edge, responses in order.
// Backpressure: addr_ok drops when MAX_OUTSTANDING are in flight (unless one retires) or on LFSR stall.
module sram_like_mem import sram_like_pkg::*; #(
    parameter int          ADDR_BITS       = 16,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          STALL_MODE      = 0,
    parameter logic [31:0] STALL_SEED      = 32'h1,
    parameter logic [7:0]  STALL_THRESH    = 8'd64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req,
    input  logic                                 wr,
    input  logic [1:0]                           size,
    input  logic [31:0]                          addr,
    input  logic [31:0]                          wdata,
    output logic [31:0]                          rdata,
    output logic                                 addr_ok,
    output logic                                 data_ok,
    output logic                                 wr_fire,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

    localparam int              DEPTH = 2 ** ADDR_BITS;
    localparam int              OW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0]   MAX_O = OW'(MAX_OUTSTANDING);

    // Contents are deliberately not reset; benches preload or write them
    logic [31:0] mem [DEPTH];

    logic [ADDR_BITS-1:0] idx;
    be_t                  be_info;
    logic [31:0]          lfsr_state;
    logic                 stall;
    logic                 accept;
    logic [31:0]          resp_dat;

    logic [LATENCY-1:0]   pipe_vld;
    logic [31:0]          pipe_dat   [LATENCY];
    logic [LATENCY-1:0]   stg_vld_in;
    logic [31:0]          stg_dat_in [LATENCY];

    // Upper address bits fall away so accesses wrap modulo DEPTH
    logic unused_bits;
    assign unused_bits = ^{addr[31:ADDR_BITS+2], lfsr_state[31:8]};

    lfsr32 #(.SEED(STALL_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .state (lfsr_state)
    );

    assign idx      = addr[ADDR_BITS+1:2];
    assign be_info  = be_from_size(size, addr[1:0]);
    assign stall    = (STALL_MODE != 0) && (lfsr_state[7:0] < STALL_THRESH);

    // A retiring response frees its slot in the same cycle, so a full window can still accept
    assign addr_ok  = rst && ((outstanding < MAX_O) || data_ok) && !stall;
    assign accept   = req && addr_ok;
    assign wr_fire  = accept && wr && !be_info.misaligned;

    // Reads see memory as of the acceptance edge; write responses carry zero
    assign resp_dat = wr ? 32'h0 : mem[idx];

    assign data_ok  = pipe_vld[LATENCY-1];
    assign rdata    = pipe_dat[LATENCY-1];

    // Byte-lane write commit at the acceptance edge
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (be_info.be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Feed for each pipeline stage: stage 0 takes the new response, others the previous stage
    always_comb begin
        stg_vld_in = '0;
        for (int i = 0; i < LATENCY; i++) stg_dat_in[i] = 32'h0;
        stg_vld_in[0] = accept;
        stg_dat_in[0] = resp_dat;
        for (int i = 1; i < LATENCY; i++) begin
            stg_vld_in[i] = pipe_vld[i-1];
            stg_dat_in[i] = pipe_dat[i-1];
        end
    end

    // Response shift register; data only moves with a valid so the output stage holds rdata
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_dat[i] <= 32'h0;
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_vld[i] <= stg_vld_in[i];
                if (stg_vld_in[i]) pipe_dat[i] <= stg_dat_in[i];
            end
        end
    end

    // In-flight counter: +1 on accept, -1 on retire, both cancel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
        end else begin
            case ({accept, data_ok})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst) outstanding <= MAX_O);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst) data_ok |-> (outstanding != '0));

endmodule

// File: tb/tb_sram_like_mem.sv
// Bench for sram_like_mem: three instances (L1/M1, L3/M2, L4/M4 with stalls), queue-based model.
// Latency: model expects each response at (acceptance edge + LATENCY), in order.
// Backpressure: model predicts addr_ok from in-flight count, retire and its own LFSR sequence.
module tb_sram_like_mem;

    localparam int LAT  [3] = '{1, 3, 4};
    localparam int MAXO [3] = '{1, 2, 4};
    localparam int SMODE[3] = '{0, 0, 1};

    logic        clk;
    logic        rst;
    logic [2:0]  req, wr, addr_ok, data_ok, wr_fire;
    logic [1:0]  size  [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [2:0]  outs  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int OW = $clog2(MAXO[g] + 1);
        logic [OW-1:0] outs_l;
        sram_like_mem #(
            .ADDR_BITS(6), .LATENCY(LAT[g]), .MAX_OUTSTANDING(MAXO[g]),
            .STALL_MODE(SMODE[g]), .STALL_SEED(32'h1), .STALL_THRESH(8'd64)
        ) u_dut (
            .clk(clk), .rst(rst), .req(req[g]), .wr(wr[g]), .size(size[g]),
            .addr(addr[g]), .wdata(wdata[g]), .rdata(rdata[g]), .addr_ok(addr_ok[g]),
            .data_ok(data_ok[g]), .wr_fire(wr_fire[g]), .outstanding(outs_l)
        );
        assign outs[g] = 3'(outs_l);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          due;
        logic [31:0] dat;
    } exp_t;

    exp_t        q       [3][$];
    logic [31:0] mm      [3][64];
    logic [31:0] rdata_m [3];
    logic [31:0] lfsr_m  [3];
    int          ecount = 0;
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          acc_cnt[3]   = '{0, 0, 0};
    int          dok_cnt[3]   = '{0, 0, 0};
    int          wf_cnt[3]    = '{0, 0, 0};
    int          stall_cnt[3] = '{0, 0, 0};

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t: got %h want %h", nm, g, $time, act, exp);
        end
    endtask

    // Reference model and compare, once per cycle between edges
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin : per_inst
            logic       dok_e, aok_e, stall_e, acc, mis, wf_e;
            int         oexp, nb, w, lo;
            exp_t       e;
            if (!rst) begin
                q[g].delete();
                rdata_m[g] = 32'h0;
                lfsr_m[g]  = 32'h1;
            end
            oexp  = q[g].size();
            dok_e = 1'b0;
            if (oexp > 0) dok_e = (q[g][0].due == ecount);
            chk("data_ok", g, 32'(data_ok[g]), 32'(dok_e));
            chk("outstanding", g, 32'(outs[g]), oexp);
            if (data_ok[g]) dok_cnt[g]++;
            if (dok_e) begin
                rdata_m[g] = q[g][0].dat;
                void'(q[g].pop_front());
            end
            chk("rdata", g, rdata[g], rdata_m[g]);
            stall_e = (SMODE[g] != 0) && (lfsr_m[g][7:0] < 8'd64);
            if (rst && stall_e) stall_cnt[g]++;
            aok_e = rst && ((oexp < MAXO[g]) || dok_e) && !stall_e;
            chk("addr_ok", g, 32'(addr_ok[g]), 32'(aok_e));
            acc  = req[g] && addr_ok[g];
            nb   = (size[g] == 2'd0) ? 1 : (size[g] == 2'd1) ? 2 : 4;
            lo   = int'(addr[g][1:0]);
            mis  = (size[g] == 2'd3) || ((lo % nb) != 0);
            wf_e = acc && wr[g] && !mis;
            chk("wr_fire", g, 32'(wr_fire[g]), 32'(wf_e));
            if (wr_fire[g]) wf_cnt[g]++;
            if (acc) begin
                acc_cnt[g]++;
                w     = int'(addr[g] >> 2) % 64;
                e.due = ecount + LAT[g];
                e.dat = 32'h0;
                if (wr[g]) begin
                    if (!mis) begin
                        for (int k = 0; k < nb; k++)
                            mm[g][w][(lo+k)*8 +: 8] = wdata[g][(lo+k)*8 +: 8];
                    end
                end else begin
                    e.dat = mm[g][w];
                end
                q[g].push_back(e);
            end
            if (rst) lfsr_m[g] = lfsr_next(lfsr_m[g]);
        end
        ecount++;
    end

    // Present a request from the current slot and hold it until accepted
    task automatic issue(input int g, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        req[g] = 1'b1; wr[g] = w; size[g] = s; addr[g] = a; wdata[g] = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (addr_ok[g]) begin
                @(posedge clk); #2;
                return;
            end
            @(posedge clk); #2;
        end
        n_cmp++; n_fail++;
        $display("FAIL accept_timeout inst%0d: got no addr_ok want addr_ok within 200 cycles", g);
    endtask

    task automatic idle(input int g, input int n);
        req[g] = 1'b0;
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic drain(input int g);
        req[g] = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (outs[g] == 3'd0 && q[g].size() == 0) return;
            @(posedge clk); #2;
        end
        n_cmp++; n_fail++;
        $display("FAIL drain_timeout inst%0d: got outstanding %0d want 0", g, outs[g]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish by 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        int wf0, acc0, dok0, st0;
        rst = 1'b0; req = '0; wr = '0;
        for (int g = 0; g < 3; g++) begin
            size[g] = 2'd0; addr[g] = 32'h0; wdata[g] = 32'h0;
        end
        #2;
        chk("lfsr_model_1", 0, lfsr_next(32'h1), 32'h8020_0003);
        chk("lfsr_model_2", 0, lfsr_next(32'h8020_0003), 32'hC030_0002);
        for (int g = 0; g < 3; g++) begin
            chk("rst_data_ok", g, 32'(data_ok[g]), 32'h0);
            chk("rst_addr_ok", g, 32'(addr_ok[g]), 32'h0);
            chk("rst_outs",    g, 32'(outs[g]),    32'h0);
            chk("rst_rdata",   g, rdata[g],        32'h0);
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // fill every word of every instance so the model knows all contents
        for (int g = 0; g < 3; g++) begin
            for (int w = 0; w < 64; w++) issue(g, 1'b1, 2'd2, 32'(w * 4), $urandom);
            drain(g);
        end

        // word write then back-to-back read of the same word
        wf0 = wf_cnt[0];
        issue(0, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF);
        issue(0, 1'b0, 2'd2, 32'h10, 32'h0);
        chk("t1_data_ok", 0, 32'(data_ok[0]), 32'h1);
        chk("t1_rdata",   0, rdata[0], 32'hDEAD_BEEF);
        idle(0, 2);
        chk("t1_wr_fire_count", 0, wf_cnt[0] - wf0, 1);

        // byte and half lane merges
        issue(0, 1'b1, 2'd2, 32'h20, 32'h1122_3344);
        issue(0, 1'b1, 2'd0, 32'h23, 32'hAA00_0000);
        issue(0, 1'b1, 2'd1, 32'h20, 32'h0000_BBCC);
        issue(0, 1'b0, 2'd2, 32'h20, 32'h0);
        chk("t2_rdata", 0, rdata[0], 32'hAA22_BBCC);

        // misaligned writes: answered, no memory change, no wr_fire
        wf0 = wf_cnt[0];
        issue(0, 1'b1, 2'd1, 32'h21, 32'hFFFF_FFFF);
        chk("t3_half_data_ok", 0, 32'(data_ok[0]), 32'h1);
        chk("t3_half_rdata",   0, rdata[0], 32'h0);
        issue(0, 1'b1, 2'd2, 32'h22, 32'hFFFF_FFFF);
        chk("t3_word_data_ok", 0, 32'(data_ok[0]), 32'h1);
        issue(0, 1'b1, 2'd3, 32'h20, 32'hFFFF_FFFF);
        issue(0, 1'b0, 2'd2, 32'h20, 32'h0);
        chk("t3_rdata_kept", 0, rdata[0], 32'hAA22_BBCC);
        idle(0, 2);
        chk("t3_wr_fire_count", 0, wf_cnt[0] - wf0, 0);

        // address wrap modulo 64 words
        issue(0, 1'b1, 2'd2, 32'hFFFF_FF30, 32'h1234_5678);
        issue(0, 1'b0, 2'd2, 32'h0000_0030, 32'h0);
        chk("wrap_rdata", 0, rdata[0], 32'h1234_5678);
        drain(0);

        // outstanding limit with req held high, LATENCY 3, MAX 2
        issue(1, 1'b1, 2'd2, 32'h0, 32'hA0);
        issue(1, 1'b1, 2'd2, 32'h4, 32'hA4);
        issue(1, 1'b1, 2'd2, 32'h8, 32'hA8);
        drain(1);
        req[1] = 1'b1; wr[1] = 1'b0; size[1] = 2'd2; addr[1] = 32'h0;
        @(posedge clk); #2;
        chk("t4_outs_1", 1, 32'(outs[1]), 32'd1);
        addr[1] = 32'h4;
        @(posedge clk); #2;
        chk("t4_outs_2", 1, 32'(outs[1]), 32'd2);
        addr[1] = 32'h8;
        @(negedge clk);
        chk("t4_blocked", 1, 32'(addr_ok[1]), 32'h0);
        @(posedge clk); #2;
        chk("t4_outs_3",    1, 32'(outs[1]), 32'd2);
        chk("t4_retire_ok", 1, 32'(addr_ok[1]), 32'h1);
        chk("t4_rdata_0",   1, rdata[1], 32'hA0);
        @(posedge clk); #2;
        chk("t4_outs_4",  1, 32'(outs[1]), 32'd2);
        chk("t4_rdata_1", 1, rdata[1], 32'hA4);
        req[1] = 1'b0;
        @(posedge clk); #2;
        chk("t4_gap", 1, 32'(data_ok[1]), 32'h0);
        @(posedge clk); #2;
        chk("t4_data_ok_2", 1, 32'(data_ok[1]), 32'h1);
        chk("t4_rdata_2",   1, rdata[1], 32'hA8);
        drain(1);

        // random traffic through the stalling instance
        acc0 = acc_cnt[2]; dok0 = dok_cnt[2]; st0 = stall_cnt[2];
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle(2, $urandom_range(1, 2));
            issue(2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
        end
        drain(2);
        chk("t5_accepts",   2, acc_cnt[2] - acc0, 200);
        chk("t5_responses", 2, dok_cnt[2] - dok0, acc_cnt[2] - acc0);
        chk("t5_stalled",   2, 32'(stall_cnt[2] > st0), 32'h1);

        // reset with requests in flight drops them
        issue(2, 1'b0, 2'd2, 32'h0, 32'h0);
        issue(2, 1'b0, 2'd2, 32'h4, 32'h0);
        rst = 1'b0; req[2] = 1'b0;
        #1;
        chk("t6_data_ok", 2, 32'(data_ok[2]), 32'h0);
        chk("t6_outs",    2, 32'(outs[2]),    32'h0);
        chk("t6_addr_ok", 2, 32'(addr_ok[2]), 32'h0);
        dok0 = dok_cnt[2];
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        chk("t6_no_late_resp", 2, dok_cnt[2] - dok0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
